// File: rtl/hazard_pkg.sv
// Shared definitions for the hazard scoreboard: exception codes, forwarding
// encodings, divider FSM states and the default exception vector.
package hazard_pkg;

   localparam logic [31:0] EXC_ERET       = 32'h0000000E;
   localparam logic [31:0] EXC_VECTOR_DEF = 32'hBFC00380;

   localparam logic [1:0] FWD_RF  = 2'b00;
   localparam logic [1:0] FWD_NET = 2'b01;

   typedef enum logic {
      IDLE = 1'b0,
      BUSY = 1'b1
   } div_state_t;

endpackage

// File: rtl/sb_cnt.sv
// Per-register result-latency countdown: clear beats load, load beats decrement,
// and the count parks at zero.
module sb_cnt #(
   parameter int LAT_W = 3
) (
   input  logic             clk,
   input  logic             resetn,
   input  logic             clr,
   input  logic             load,
   input  logic [LAT_W-1:0] load_val,
   input  logic             dec,
   output logic [LAT_W-1:0] cnt
);

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         cnt <= '0;
      end else if (clr) begin
         cnt <= '0;
      end else if (load) begin
         cnt <= load_val;
      end else if (dec && (cnt != '0)) begin
         cnt <= cnt - 1'b1;
      end
   end

endmodule

// File: rtl/hazard_sb.sv
// Pipeline hazard scoreboard: operand interlock/forwarding, divider busy FSM,
// exception redirect. Define HAZARD_SB_PERF_EN to add the perf counter outputs.
//
// state | meaning
// IDLE  | no divide in flight; div_start without mem_wait launches one
// BUSY  | divide running, busy_cnt counts down to 0, F/D/E held
module hazard_sb import hazard_pkg::*; #(
   parameter int          REG_NUM    = 32,
   parameter int          LAT_W      = 3,
   parameter int          DIV_CYCLES = 32,
   parameter logic [31:0] EXC_VECTOR = EXC_VECTOR_DEF
) (
   input  logic                       clk,
   input  logic                       resetn,
   input  logic                       issue_valid,
   input  logic                       issue_wr,
   input  logic [$clog2(REG_NUM)-1:0] issue_rd,
   input  logic [LAT_W-1:0]           issue_lat,
   input  logic [$clog2(REG_NUM)-1:0] rsD,
   input  logic [$clog2(REG_NUM)-1:0] rtD,
   input  logic                       use_rsD,
   input  logic                       use_rtD,
   input  logic                       brD,
   input  logic                       div_start,
   input  logic                       mem_wait,
   input  logic                       except_valid,
   input  logic [31:0]                except_type,
   input  logic [31:0]                epc,
   output logic                       stallF,
   output logic                       stallD,
   output logic                       stallE,
   output logic                       stallM,
   output logic                       flushF,
   output logic                       flushD,
   output logic                       flushE,
   output logic                       flushM,
   output logic                       flushW,
   output logic [1:0]                 fwda,
   output logic [1:0]                 fwdb,
   output logic                       pc_redirect,
   output logic [31:0]                newpc,
   output logic                       div_done
`ifdef HAZARD_SB_PERF_EN
   ,
   output logic [31:0]                perf_hz_stall,
   output logic [31:0]                perf_mem_stall,
   output logic [31:0]                perf_flush
`endif
);

   localparam int REG_W = $clog2(REG_NUM);
   localparam int DIV_W = (DIV_CYCLES > 1) ? $clog2(DIV_CYCLES) : 1;

   logic [REG_NUM-1:0][LAT_W-1:0] cnt;
   div_state_t                    state;
   logic [DIV_W-1:0]              busy_cnt;
   logic                          busy;
   logic                          hz_a;
   logic                          hz_b;
   logic                          hz_stall_ev;
   logic                          issue_go;

   assign busy = (state == BUSY);

   // Branches compare in D, so they cannot take a value still one cycle out.
   assign hz_a = use_rsD && (rsD != '0) &&
                 (brD ? (cnt[rsD] != '0) : (cnt[rsD] > LAT_W'(1)));
   assign hz_b = use_rtD && (rtD != '0) &&
                 (brD ? (cnt[rtD] != '0) : (cnt[rtD] > LAT_W'(1)));

   assign hz_stall_ev = resetn && !except_valid && !mem_wait && !busy && (hz_a || hz_b);

   always_comb begin
      stallF      = 1'b0;
      stallD      = 1'b0;
      stallE      = 1'b0;
      stallM      = 1'b0;
      flushF      = 1'b0;
      flushD      = 1'b0;
      flushE      = 1'b0;
      flushM      = 1'b0;
      flushW      = 1'b0;
      pc_redirect = 1'b0;
      newpc       = '0;
      if (resetn) begin
         if (except_valid) begin
            flushF      = 1'b1;
            flushD      = 1'b1;
            flushE      = 1'b1;
            flushM      = 1'b1;
            flushW      = 1'b1;
            pc_redirect = 1'b1;
            newpc       = (except_type == EXC_ERET) ? epc : EXC_VECTOR;
         end else if (mem_wait) begin
            stallF = 1'b1;
            stallD = 1'b1;
            stallE = 1'b1;
            stallM = 1'b1;
         end else if (busy) begin
            stallF = 1'b1;
            stallD = 1'b1;
            stallE = 1'b1;
         end else if (hz_a || hz_b) begin
            stallF = 1'b1;
            stallD = 1'b1;
            flushE = 1'b1;
         end
      end
   end

   assign fwda = (resetn && (cnt[rsD] == LAT_W'(1))) ? FWD_NET : FWD_RF;
   assign fwdb = (resetn && (cnt[rtD] == LAT_W'(1))) ? FWD_NET : FWD_RF;

   assign issue_go = issue_valid && issue_wr && (issue_rd != '0) && !stallD && !except_valid;

   assign cnt[0] = '0;

   for (genvar i = 1; i < REG_NUM; i++) begin : g_cnt
      sb_cnt #(.LAT_W(LAT_W)) u_cnt (
         .clk      (clk),
         .resetn   (resetn),
         .clr      (except_valid),
         .load     (issue_go && (issue_rd == REG_W'(i))),
         .load_val (issue_lat),
         .dec      (!stallE),
         .cnt      (cnt[i])
      );
   end

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         state    <= IDLE;
         busy_cnt <= '0;
         div_done <= 1'b0;
      end else if (except_valid) begin
         state    <= IDLE;
         busy_cnt <= '0;
         div_done <= 1'b0;
      end else begin
         div_done <= 1'b0;
         case (state)
            IDLE: begin
               if (div_start && !mem_wait) begin
                  state    <= BUSY;
                  busy_cnt <= DIV_W'(DIV_CYCLES - 1);
               end
            end
            BUSY: begin
               if (busy_cnt == '0) begin
                  state    <= IDLE;
                  div_done <= 1'b1;
               end else begin
                  busy_cnt <= busy_cnt - 1'b1;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

`ifdef HAZARD_SB_PERF_EN
   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         perf_hz_stall  <= '0;
         perf_mem_stall <= '0;
         perf_flush     <= '0;
      end else begin
         if (hz_stall_ev)  perf_hz_stall  <= perf_hz_stall + 32'd1;
         if (mem_wait)     perf_mem_stall <= perf_mem_stall + 32'd1;
         if (except_valid) perf_flush     <= perf_flush + 32'd1;
      end
   end
`endif

endmodule

// File: tb/tb_hazard_sb.sv
// Scoreboard bench for hazard_sb: the driver predicts each cycle's outputs from
// a pending-cycles model and queues them; a negedge monitor pops and compares.
module tb_hazard_sb;

   localparam int RN = 32;
   localparam int DC = 32;

   logic        clk = 1'b0;
   logic        resetn;
   logic        issue_valid, issue_wr;
   logic [4:0]  issue_rd;
   logic [2:0]  issue_lat;
   logic [4:0]  rsD, rtD;
   logic        use_rsD, use_rtD, brD, div_start, mem_wait, except_valid;
   logic [31:0] except_type, epc;
   logic        stallF, stallD, stallE, stallM;
   logic        flushF, flushD, flushE, flushM, flushW;
   logic [1:0]  fwda, fwdb;
   logic        pc_redirect;
   logic [31:0] newpc;
   logic        div_done;

   always #5 clk = ~clk;

   hazard_sb dut (
      .clk(clk), .resetn(resetn), .issue_valid(issue_valid), .issue_wr(issue_wr),
      .issue_rd(issue_rd), .issue_lat(issue_lat), .rsD(rsD), .rtD(rtD),
      .use_rsD(use_rsD), .use_rtD(use_rtD), .brD(brD), .div_start(div_start),
      .mem_wait(mem_wait), .except_valid(except_valid), .except_type(except_type),
      .epc(epc), .stallF(stallF), .stallD(stallD), .stallE(stallE), .stallM(stallM),
      .flushF(flushF), .flushD(flushD), .flushE(flushE), .flushM(flushM),
      .flushW(flushW), .fwda(fwda), .fwdb(fwdb), .pc_redirect(pc_redirect),
      .newpc(newpc), .div_done(div_done)
   );

   typedef struct packed {
      logic [3:0]  st;
      logic [4:0]  fl;
      logic [1:0]  fa;
      logic [1:0]  fb;
      logic        pr;
      logic [31:0] np;
      logic        dd;
   } exp_t;

   exp_t q[$];
   int   checks = 0;
   int   errors = 0;
   int   cyc = 0;
   int   pend[RN];
   int   div_rem;
   bit   done_q;
   int   n_stall_e;
   int   n_done;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] ex);
      checks++;
      if (act !== ex) begin
         errors++;
         $display("FAIL %s cycle %0d: got %h expected %h", nm, cyc, act, ex);
      end
   endtask

   function automatic exp_t predict();
      exp_t e = '0;
      bit   ha, hb;
      if (!resetn) return e;
      ha = use_rsD && (rsD != 0) && (brD ? (pend[rsD] > 0) : (pend[rsD] > 1));
      hb = use_rtD && (rtD != 0) && (brD ? (pend[rtD] > 0) : (pend[rtD] > 1));
      e.fa = (pend[rsD] == 1) ? 2'b01 : 2'b00;
      e.fb = (pend[rtD] == 1) ? 2'b01 : 2'b00;
      e.dd = done_q;
      if (except_valid) begin
         e.fl = 5'b11111;
         e.pr = 1'b1;
         e.np = (except_type == 32'h0000000E) ? epc : 32'hBFC00380;
      end else if (mem_wait) begin
         e.st = 4'b1111;
      end else if (div_rem > 0) begin
         e.st = 4'b1110;
      end else if (ha || hb) begin
         e.st = 4'b1100;
         e.fl = 5'b00100;
      end
      return e;
   endfunction

   task automatic advance(input exp_t e);
      if (!resetn || except_valid) begin
         for (int r = 0; r < RN; r++) pend[r] = 0;
         div_rem = 0;
         done_q  = 1'b0;
      end else begin
         bit nd = 1'b0;
         for (int r = 1; r < RN; r++) begin
            if (issue_valid && issue_wr && (issue_rd == 5'(r)) && !e.st[2])
               pend[r] = int'(issue_lat);
            else if (!e.st[1] && pend[r] > 0)
               pend[r] = pend[r] - 1;
         end
         if (div_rem > 0) begin
            div_rem = div_rem - 1;
            nd = (div_rem == 0);
         end else if (div_start && !mem_wait) begin
            div_rem = DC;
         end
         done_q = nd;
      end
   endtask

   task automatic step();
      exp_t e = predict();
      q.push_back(e);
      @(posedge clk);
      #1;
      advance(e);
      cyc++;
   endtask

   task automatic clr_in();
      issue_valid = 0; issue_wr = 0; issue_rd = 0; issue_lat = 0;
      rsD = 0; rtD = 0; use_rsD = 0; use_rtD = 0; brD = 0;
      div_start = 0; mem_wait = 0; except_valid = 0; except_type = 0; epc = 0;
   endtask

   initial begin
      forever begin
         @(negedge clk);
         if (q.size() > 0) begin
            exp_t e;
            e = q.pop_front();
            chk("stalls", 32'({stallF, stallD, stallE, stallM}), 32'(e.st));
            chk("flushes", 32'({flushF, flushD, flushE, flushM, flushW}), 32'(e.fl));
            chk("fwda", 32'(fwda), 32'(e.fa));
            chk("fwdb", 32'(fwdb), 32'(e.fb));
            chk("pc_redirect", 32'(pc_redirect), 32'(e.pr));
            chk("newpc", newpc, e.np);
            chk("div_done", 32'(div_done), 32'(e.dd));
            if (stallE) n_stall_e++;
            if (div_done) n_done++;
         end
      end
   end

   initial begin
      resetn = 0;
      clr_in();
      for (int r = 0; r < RN; r++) pend[r] = 0;
      div_rem = 0; done_q = 0; n_stall_e = 0; n_done = 0;
      @(posedge clk);
      #1;
      // in reset with every event asserted: all outputs must stay 0
      except_valid = 1; mem_wait = 1; div_start = 1; issue_valid = 1; issue_wr = 1;
      issue_rd = 3; issue_lat = 2; use_rsD = 1; rsD = 3;
      step(); step();
      clr_in(); resetn = 1;
      // load to r8 then dependent use
      issue_valid = 1; issue_wr = 1; issue_rd = 8; issue_lat = 2; step();
      issue_rd = 10; issue_lat = 1; use_rsD = 1; rsD = 8; step(); step();
      clr_in(); step();
      // ALU to r9 then branch on r9
      issue_valid = 1; issue_wr = 1; issue_rd = 9; issue_lat = 1; step();
      clr_in(); brD = 1; use_rsD = 1; rsD = 9; step(); step();
      clr_in();
      // divide with mid-run mem_wait and ignored restart
      n_stall_e = 0; n_done = 0;
      div_start = 1; step(); div_start = 0;
      for (int i = 0; i < 40; i++) begin
         mem_wait  = (i >= 10 && i < 13);
         div_start = (i == 5);
         step();
      end
      clr_in();
      chk("div_busy_cycles", 32'(n_stall_e), 32'd32);
      chk("div_done_pulses", 32'(n_done), 32'd1);
      // exception while busy with pending r5
      issue_valid = 1; issue_wr = 1; issue_rd = 5; issue_lat = 3; div_start = 1; step();
      clr_in(); step(); step(); step();
      except_valid = 1; except_type = 32'd4; epc = 32'h8000_1234; step();
      clr_in(); use_rsD = 1; rsD = 5; use_rtD = 1; rtD = 5; step();
      clr_in(); except_valid = 1; except_type = 32'h0000000E; epc = 32'h8000_0040; step();
      clr_in(); step();
      // reset mid-divide with pending r6
      issue_valid = 1; issue_wr = 1; issue_rd = 6; issue_lat = 3; div_start = 1; step();
      clr_in(); step(); step();
      resetn = 0; use_rsD = 1; rsD = 6; mem_wait = 1; step();
      resetn = 1; clr_in(); brD = 1; use_rsD = 1; rsD = 6; use_rtD = 1; rtD = 6; step();
      clr_in();
      // r0 never pending
      issue_valid = 1; issue_wr = 1; issue_rd = 0; issue_lat = 3; step();
      clr_in(); brD = 1; use_rsD = 1; rsD = 0; use_rtD = 1; rtD = 0; step();
      clr_in(); use_rsD = 1; rsD = 0; step();
      // randomized traffic
      for (int i = 0; i < 600; i++) begin
         resetn       = ($urandom_range(0, 199) != 0);
         issue_valid  = ($urandom_range(0, 1) != 0);
         issue_wr     = ($urandom_range(0, 4) != 0);
         issue_rd     = 5'($urandom_range(0, 7));
         issue_lat    = 3'($urandom_range(0, 7));
         rsD          = 5'($urandom_range(0, 7));
         rtD          = 5'($urandom_range(0, 7));
         use_rsD      = ($urandom_range(0, 9) < 7);
         use_rtD      = ($urandom_range(0, 9) < 7);
         brD          = ($urandom_range(0, 4) == 0);
         div_start    = ($urandom_range(0, 19) == 0);
         mem_wait     = ($urandom_range(0, 9) == 0);
         except_valid = ($urandom_range(0, 29) == 0);
         except_type  = ($urandom_range(0, 1) != 0) ? 32'h0000000E : 32'd4;
         epc          = $urandom;
         step();
      end
      clr_in(); resetn = 1;
      step(); step();
      chk("scoreboard_drained", 32'(q.size()), 32'd0);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/hazard_sb.md
HAZARD_SB -- requirements
Module: hazard_sb

Interface
REQ-001 The block SHALL have parameter REG_NUM, default 32, giving the number of architectural registers.
REQ-002 The block SHALL have parameter LAT_W, default 3, giving the width of the per-register result-latency counter.
REQ-003 The block SHALL have parameter DIV_CYCLES, default 32, giving the divider busy time in cycles.
REQ-004 The block SHALL have parameter EXC_VECTOR, default 32'hBFC00380, giving the exception redirect target.
REQ-005 The block SHALL have these ports:
- clk  in  1  single clock; all state updates on the rising edge.
- resetn  in  1  reset; asynchronous, active-low.
- issue_valid, issue_wr  in  1 each  instruction leaving D; the instruction writes a register.
- issue_rd  in  $clog2(REG_NUM)  destination register.
- issue_lat  in  LAT_W  cycles until the result can be forwarded (ALU=1, load=2).
- rsD, rtD  in  $clog2(REG_NUM)  source registers in D.
- use_rsD, use_rtD  in  1 each  the D instruction reads the source.
- brD  in  1  the D instruction resolves its operands in D (branch, jr, jalr).
- div_start  in  1  a div or divu enters E.
- mem_wait  in  1  data SRAM not ready.
- except_valid  in  1  an exception or eret is committing in M.
- except_type, epc  in  32 each  exception code; return PC.
- stallF, stallD, stallE, stallM  out  1 each  hold the stage.
- flushF, flushD, flushE, flushM, flushW  out  1 each  clear the stage.
- fwda, fwdb  out  2 each  operand source for D: 00 = regfile, 01 = forwarding network.
- pc_redirect  out  1  load newpc into PC.
- newpc  out  32  redirect target.
- div_done  out  1  one-cycle pulse when the divide completes.

Function
REQ-006 The block SHALL keep a countdown counter cnt[r] of LAT_W bits per register; cnt[0] SHALL stay 0.
REQ-007 On an accepted issue (issue_valid & issue_wr & issue_rd!=0 & ~stallD & ~except_valid), cnt[issue_rd] SHALL load issue_lat; the latest issue SHALL overwrite any older value.
REQ-008 When ~stallE, every other nonzero cnt SHALL decrement by 1; when stallE, all counters SHALL hold.
REQ-009 A same-cycle issue to a register SHALL take priority over that register's decrement.
REQ-010 The operand hazard for A SHALL be use_rsD & rsD!=0 & (brD ? cnt[rsD]!=0 : cnt[rsD]>1); the hazard for B SHALL use rtD in the same way.
REQ-011 fwda SHALL be 01 when cnt[rsD]==1, else 00; fwdb SHALL use cnt[rtD] in the same way.
REQ-012 The divider FSM SHALL have two states, IDLE and BUSY.
- IDLE -> BUSY on div_start & ~mem_wait; the busy counter loads DIV_CYCLES-1.
- In BUSY the counter decrements every cycle, including during mem_wait.
- At 0: div_done=1 for one cycle, then IDLE.
- div_start while BUSY SHALL be ignored.
REQ-013 While BUSY, stallF, stallD and stallE SHALL be 1.
REQ-014 While mem_wait=1, stallF, stallD, stallE and stallM SHALL be 1, and no flush SHALL be raised by a hazard.
REQ-015 On an operand hazard only, stallF=stallD=1 and flushE=1, so a bubble enters E.
REQ-016 Events SHALL be prioritised in this order: except_valid > mem_wait > BUSY > operand hazard.
REQ-017 On except_valid, in the same cycle (combinational):
- all flush outputs SHALL be 1, all stalls SHALL be 0, and pc_redirect SHALL be 1;
- newpc SHALL be epc if except_type==32'h0000000E, else EXC_VECTOR.
At the next edge, all cnt SHALL clear and the FSM SHALL go to IDLE with no div_done pulse.
REQ-018 When no event is active, every stall and flush output SHALL be 0, pc_redirect SHALL be 0, and newpc SHALL be 0.

Reset
REQ-019 While resetn=0, all cnt, the FSM (IDLE), the busy counter and the perf counters SHALL be 0.
REQ-020 While resetn=0, all outputs SHALL be 0.
REQ-021 The first accepted issue SHALL be the one sampled at the first edge after resetn rises.

Configuration
REQ-022 With HAZARD_SB_PERF_EN defined, the block SHALL add these outputs:
- perf_hz_stall  32  counts operand-hazard stall cycles.
- perf_mem_stall  32  counts mem_wait cycles.
- perf_flush  32  counts except_valid cycles.
Each counter SHALL wrap at 2^32 and clear on reset.
REQ-023 With HAZARD_SB_PERF_EN undefined, these ports and counters SHALL be absent and all other behaviour SHALL be identical.

Structure
REQ-024 The shared package hazard_pkg SHALL hold:
- exception codes (ERET 32'h0E);
- the fwd encodings FWD_RF and FWD_NET;
- the FSM state enum (IDLE, BUSY);
- the default EXC_VECTOR.
REQ-025 The per-register counter SHALL be the sub-module sb_cnt (load, decrement, clear, hold), instantiated REG_NUM-1 times.

Verification
REQ-026 The bench SHALL cover at least these directed scenarios:
- Load to r8 (lat=2), next D uses rs=8 -> one cycle with stallD=1 and flushE=1, then fwda=01 and no stall.
- ALU to r9 (lat=1) followed by beq on r9 (brD=1) -> one stall cycle, then cnt[9]=0 and fwda=00.
- div_start with DIV_CYCLES=32 -> stallE=1 for 32 cycles, then one div_done pulse; a mem_wait mid-divide does not extend the busy time.
- except_valid with except_type=4 while BUSY -> newpc=32'hBFC00380, all flushes 1, next cycle IDLE with all cnt=0; except_type=32'h0E -> newpc=epc.
- resetn asserted mid-divide with pending cnt -> all outputs 0 immediately; after release, a read of any register causes no stall.
- Issue to r0 -> never pending; rsD=0 never stalls.
